// File: rtl/ext_bus_arbiter.sv
// Shares the single external bus between instruction fetch and load/store, one fixed-length
// access at a time. Define FAIR_ARB_EN for round-robin arbitration on contention.
module ext_bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk_from_external,
    input  logic        reset_from_external,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    input  logic [31:0] inputdata_from_external_bus,
    output logic [31:0] outputdata_to_external_bus,
    output logic [31:0] address_to_external_bus_from_cpu,
    output logic [3:0]  control_output_to_external_bus,
    output logic        bus_busy
);
    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gnt_ls_q, gnt_ls_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic        if_done_q, if_done_d;
    logic        ls_done_q, ls_done_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    logic if_pend, ls_pend, grant, pick_ls, last_cycle;

    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        return (sz == 2'b11) ? 2'b10 : sz;
    endfunction

    // A port whose done pulse is high this cycle is still holding its old request.
    assign if_pend    = if_req & ~if_done_q;
    assign ls_pend    = ls_req & ~ls_done_q;
    assign grant      = (state_q == IDLE) && (if_pend || ls_pend);
    assign last_cycle = (state_q == ACCESS) && (cnt_q == 4'd0);

`ifdef FAIR_ARB_EN
    logic last_ls_q;

    assign pick_ls = (if_pend && ls_pend) ? ~last_ls_q : ls_pend;

    always_ff @(posedge clk_from_external) begin
        if (reset_from_external) begin
            last_ls_q <= 1'b1;
        end else if (grant) begin
            last_ls_q <= pick_ls;
        end
    end
`else
    assign pick_ls = ls_pend;
`endif

    always_ff @(posedge clk_from_external) begin
        if (reset_from_external) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            gnt_ls_q   <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            ctrl_q     <= 4'd0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_rdata_q <= 32'd0;
            ls_rdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_ls_q   <= gnt_ls_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ctrl_q     <= ctrl_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gnt_ls_d = gnt_ls_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d  = ACCESS;
                    cnt_d    = 4'(WAIT_CYCLES);
                    gnt_ls_d = pick_ls;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus lines are loaded at grant so they are valid from the first ACCESS cycle.
    always_comb begin
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ctrl_d     = ctrl_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        if (grant) begin
            if (pick_ls) begin
                addr_d  = ls_addr;
                wdata_d = ls_we ? ls_wdata : 32'd0;
                ctrl_d  = {norm_size(ls_size), ls_we ? 2'b10 : 2'b01};
            end else begin
                addr_d  = if_addr;
                wdata_d = 32'd0;
                ctrl_d  = 4'b1001;
            end
        end else if (last_cycle) begin
            addr_d  = 32'd0;
            wdata_d = 32'd0;
            ctrl_d  = 4'd0;
            if (gnt_ls_q) begin
                ls_done_d  = 1'b1;
                ls_rdata_d = inputdata_from_external_bus;
            end else begin
                if_done_d  = 1'b1;
                if_rdata_d = inputdata_from_external_bus;
            end
        end
    end

    assign if_done                          = if_done_q;
    assign ls_done                          = ls_done_q;
    assign if_rdata                         = if_rdata_q;
    assign ls_rdata                         = ls_rdata_q;
    assign outputdata_to_external_bus       = wdata_q;
    assign address_to_external_bus_from_cpu = addr_q;
    assign control_output_to_external_bus   = ctrl_q;
    assign bus_busy                         = (state_q == ACCESS);
endmodule
